// File: rtl/eclair_datapath_core.sv
`default_nettype none
// ============================================================================
// Module   : eclair_datapath_core
// Brief    : ECLair datapath slice: ALU, Z register, loadable PC and
//            active-low register-load decoder. ALU_FLAGS_EN adds a flags reg.
// Revision : 1.0 - initial release
// ============================================================================
module eclair_datapath_core #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             alu_mode,
    input  logic [3:0]       alu_op,
    input  logic             c_in,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] alu_z,
    input  logic             z_load,
    output logic [WIDTH-1:0] reg_z,
    input  logic             pc_ce,
    input  logic             pc_load,
    output logic [WIDTH-1:0] pc,
    input  logic             dmx_en,
    input  logic [2:0]       dmx_sel,
    output logic [7:0]       dmx_out,
    output logic [3:0]       flags
);

    localparam logic [WIDTH-1:0] C_PC_STEP = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_sum_lo;
    logic [WIDTH-1:0] w_logic;
    logic [WIDTH-1:0] w_alu_z;
    logic             w_arith_valid;
    logic [7:0]       w_dmx;
    logic [WIDTH-1:0] r_z;
    logic [WIDTH-1:0] r_pc;

    // Arithmetic operand pair selection; ops 8-15 are reserved
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        case (alu_op[2:0])
            3'd0: w_op_a = x;
            3'd1: begin w_op_a = x;  w_op_b = y;  end
            3'd2: begin w_op_a = x;  w_op_b = ~y; end
            3'd3: begin w_op_a = x;  w_op_b = '1; end
            3'd4: w_op_a = y;
            3'd5: begin w_op_a = ~x; w_op_b = y;  end
            3'd6: begin w_op_a = x;  w_op_b = x;  end
            default: ;
        endcase
    end

    assign w_arith_valid = ~alu_op[3];

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] w_sum;
    logic           w_carry;
    logic           w_ovf;
    logic [3:0]     r_flags;

    assign w_sum    = {1'b0, w_op_a} + {1'b0, w_op_b} + {{WIDTH{1'b0}}, c_in};
    assign w_sum_lo = w_sum[WIDTH-1:0];
    assign w_carry  = ~alu_mode & w_arith_valid & w_sum[WIDTH];
    assign w_ovf    = ~alu_mode & w_arith_valid
                    & (w_op_a[WIDTH-1] == w_op_b[WIDTH-1])
                    & (w_sum[WIDTH-1] != w_op_a[WIDTH-1]);

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_flags <= 4'b0000;
        end else if (z_load) begin
            r_flags <= {w_ovf, w_alu_z[WIDTH-1], (w_alu_z == '0), w_carry};
        end
    end

    assign flags = r_flags;
`else
    assign w_sum_lo = w_op_a + w_op_b + {{(WIDTH-1){1'b0}}, c_in};
    assign flags    = 4'b0000;
`endif

    // 74181 logic functions, active-high data
    always_comb begin
        w_logic = '0;
        case (alu_op)
            4'd0:  w_logic = ~x;
            4'd1:  w_logic = ~(x | y);
            4'd2:  w_logic = ~x & y;
            4'd3:  w_logic = '0;
            4'd4:  w_logic = ~(x & y);
            4'd5:  w_logic = ~y;
            4'd6:  w_logic = x ^ y;
            4'd7:  w_logic = x & ~y;
            4'd8:  w_logic = ~x | y;
            4'd9:  w_logic = ~(x ^ y);
            4'd10: w_logic = y;
            4'd11: w_logic = x & y;
            4'd12: w_logic = '1;
            4'd13: w_logic = x | ~y;
            4'd14: w_logic = x | y;
            4'd15: w_logic = x;
            default: w_logic = '0;
        endcase
    end

    assign w_alu_z = alu_mode ? w_logic : (w_arith_valid ? w_sum_lo : '0);
    assign alu_z   = w_alu_z;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_z <= '0;
        end else if (z_load) begin
            r_z <= w_alu_z;
        end
    end

    // Load takes the pre-edge Z, so a same-edge z_load is not seen by the PC
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_pc <= PC_RESET;
        end else if (pc_load) begin
            r_pc <= r_z;
        end else if (pc_ce) begin
            r_pc <= r_pc + C_PC_STEP;
        end
    end

    assign reg_z = r_z;
    assign pc    = r_pc;

    always_comb begin
        w_dmx = 8'hFF;
        if (dmx_en) begin
            w_dmx[dmx_sel] = 1'b0;
        end
    end

    assign dmx_out = w_dmx;

endmodule

`default_nettype wire

// File: tb/tb_eclair_datapath_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_eclair_datapath_core
// Brief    : Self-checking bench for eclair_datapath_core against a
//            behavioural ALU/PC/decoder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eclair_datapath_core;

    logic        clk = 1'b0;
    logic        _reset;
    logic        alu_mode;
    logic [3:0]  alu_op;
    logic        c_in;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] alu_z;
    logic        z_load;
    logic [15:0] reg_z;
    logic        pc_ce;
    logic        pc_load;
    logic [15:0] pc;
    logic        dmx_en;
    logic [2:0]  dmx_sel;
    logic [7:0]  dmx_out;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_z;
    logic [15:0] m_pc;
    logic [3:0]  m_flags;

    always #5 clk = ~clk;

    eclair_datapath_core #(.WIDTH(16), .PC_RESET(16'h0000)) dut (
        .clk(clk), ._reset(_reset), .alu_mode(alu_mode), .alu_op(alu_op),
        .c_in(c_in), .x(x), .y(y), .alu_z(alu_z), .z_load(z_load),
        .reg_z(reg_z), .pc_ce(pc_ce), .pc_load(pc_load), .pc(pc),
        .dmx_en(dmx_en), .dmx_sel(dmx_sel), .dmx_out(dmx_out), .flags(flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {V,N,Zf,C,result} using integer arithmetic on the operand pair
    function automatic logic [19:0] ref_alu(input logic md, input logic [3:0] op,
                                            input logic ci, input logic [15:0] xv,
                                            input logic [15:0] yv);
        int a, b, s, sa, sb, ss;
        logic [15:0] r;
        logic c, v;
        a = 0; b = 0; s = 0; r = 16'h0000; c = 1'b0; v = 1'b0;
        if (!md) begin
            case (op)
                4'd0: begin a = xv;               b = 0;              end
                4'd1: begin a = xv;               b = yv;             end
                4'd2: begin a = xv;               b = 65535 - int'(yv); end
                4'd3: begin a = xv;               b = 65535;          end
                4'd4: begin a = yv;               b = 0;              end
                4'd5: begin a = 65535 - int'(xv); b = yv;             end
                4'd6: begin a = xv;               b = xv;             end
                default: begin a = 0; b = 0; end
            endcase
            if (op < 4'd8) begin
                s  = a + b + int'(ci);
                r  = s[15:0];
                c  = (s >= 65536);
                sa = (a >= 32768) ? a - 65536 : a;
                sb = (b >= 32768) ? b - 65536 : b;
                ss = sa + sb + int'(ci);
                v  = (ss > 32767) || (ss < -32768);
            end
        end else begin
            case (op)
                4'd0:  r = ~xv;
                4'd1:  r = ~(xv | yv);
                4'd2:  r = ~xv & yv;
                4'd3:  r = 16'h0000;
                4'd4:  r = ~(xv & yv);
                4'd5:  r = ~yv;
                4'd6:  r = xv ^ yv;
                4'd7:  r = xv & ~yv;
                4'd8:  r = ~xv | yv;
                4'd9:  r = ~(xv ^ yv);
                4'd10: r = yv;
                4'd11: r = xv & yv;
                4'd12: r = 16'hFFFF;
                4'd13: r = xv | ~yv;
                4'd14: r = xv | yv;
                default: r = xv;
            endcase
        end
        return {v, r[15], (r == 16'h0000), c, r};
    endfunction

    function automatic logic [7:0] ref_dmx(input logic en, input logic [2:0] sel);
        return en ? (8'hFF ^ (8'h01 << sel)) : 8'hFF;
    endfunction

    function automatic logic [3:0] exp_flags();
`ifdef ALU_FLAGS_EN
        return m_flags;
`else
        return 4'b0000;
`endif
    endfunction

    // Apply inputs, check combinational outputs, clock once, check state
    task automatic step(input logic md, input logic [3:0] op, input logic ci,
                        input logic [15:0] xv, input logic [15:0] yv,
                        input logic zl, input logic pl, input logic ce,
                        input logic en, input logic [2:0] sel);
        logic [19:0] r;
        logic [15:0] npc;
        alu_mode = md; alu_op = op; c_in = ci; x = xv; y = yv;
        z_load = zl; pc_load = pl; pc_ce = ce; dmx_en = en; dmx_sel = sel;
        #1;
        r = ref_alu(md, op, ci, xv, yv);
        chk("alu_z", {16'h0, alu_z}, {16'h0, r[15:0]});
        chk("dmx_out", {24'h0, dmx_out}, {24'h0, ref_dmx(en, sel)});
        npc = pl ? m_z : (ce ? m_pc + 16'd1 : m_pc);
        if (zl) begin
            m_z     = r[15:0];
            m_flags = r[19:16];
        end
        m_pc = npc;
        @(posedge clk);
        #1;
        chk("reg_z", {16'h0, reg_z}, {16'h0, m_z});
        chk("pc", {16'h0, pc}, {16'h0, m_pc});
        chk("flags", {28'h0, flags}, {28'h0, exp_flags()});
    endtask

    logic [15:0] logic_tbl [16];
    logic [7:0]  dmx_tbl [8];

    initial begin
        logic_tbl = '{16'h0F0F, 16'h0303, 16'h0C0C, 16'h0000, 16'h3F3F, 16'h3333,
                      16'h3C3C, 16'h3030, 16'hCFCF, 16'hC3C3, 16'hCCCC, 16'hC0C0,
                      16'hFFFF, 16'hF3F3, 16'hFCFC, 16'hF0F0};
        dmx_tbl   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        _reset = 1'b0; alu_mode = 1'b0; alu_op = 4'd0; c_in = 1'b0;
        x = 16'h0; y = 16'h0; z_load = 1'b0; pc_load = 1'b0; pc_ce = 1'b0;
        dmx_en = 1'b0; dmx_sel = 3'd0;
        m_z = 16'h0; m_pc = 16'h0; m_flags = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg_z", {16'h0, reg_z}, 32'h0);
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_flags", {28'h0, flags}, 32'h0);
        _reset = 1'b1;

        // Subtraction 5-7
        step(1'b0, 4'd2, 1'b1, 16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("sub_reg_z", {16'h0, reg_z}, 32'h0000_FFFE);
`ifdef ALU_FLAGS_EN
        chk("sub_flags", {28'h0, flags}, 32'h4);
`endif
        // Overflow 7FFF+1 (no z_load: keep FFFE for the PC test)
        alu_mode = 1'b0; alu_op = 4'd1; c_in = 1'b0; x = 16'h7FFF; y = 16'h0001;
        #1;
        chk("ovf_alu_z", {16'h0, alu_z}, 32'h0000_8000);

        // PC load from Z, then wrap through 0xFFFF
        step(1'b0, 4'd1, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("pc_load", {16'h0, pc}, 32'h0000_FFFE);
        step(1'b0, 4'd0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        chk("pc_inc1", {16'h0, pc}, 32'h0000_FFFF);
        step(1'b0, 4'd0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        chk("pc_wrap", {16'h0, pc}, 32'h0000_0000);
        step(1'b0, 4'd0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        chk("pc_inc3", {16'h0, pc}, 32'h0000_0001);
        step(1'b0, 4'd0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        chk("pc_load_wins", {16'h0, pc}, 32'h0000_FFFE);

        // Overflow captured into Z while PC takes the old Z
        step(1'b0, 4'd1, 1'b0, 16'h7FFF, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("pc_old_z", {16'h0, pc}, 32'h0000_FFFE);
        chk("ovf_reg_z", {16'h0, reg_z}, 32'h0000_8000);
`ifdef ALU_FLAGS_EN
        chk("ovf_flags", {28'h0, flags}, 32'hC);
`endif

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), 1'b0, 16'hF0F0, 16'hCCCC, 1'b1, 1'b0, 1'b0, 1'b1, 3'(i));
            chk($sformatf("logic_op%0d", i), {16'h0, reg_z}, {16'h0, logic_tbl[i]});
        end

        for (int i = 0; i < 8; i++) begin
            dmx_en = 1'b1; dmx_sel = 3'(i);
            #1;
            chk($sformatf("dmx_sel%0d", i), {24'h0, dmx_out}, {24'h0, dmx_tbl[i]});
            dmx_en = 1'b0;
            #1;
            chk($sformatf("dmx_off%0d", i), {24'h0, dmx_out}, 32'hFF);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 4'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                 1'($urandom), 3'($urandom));
        end

        // Asynchronous reset mid-cycle with non-trivial state
        step(1'b0, 4'd0, 1'b1, 16'h1234, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        z_load = 1'b0; pc_load = 1'b0; pc_ce = 1'b0;
        #2;
        _reset = 1'b0;
        #1;
        chk("async_reg_z", {16'h0, reg_z}, 32'h0);
        chk("async_pc", {16'h0, pc}, 32'h0);
        chk("async_flags", {28'h0, flags}, 32'h0);
        m_z = 16'h0; m_pc = 16'h0; m_flags = 4'h0;
        @(posedge clk);
        #1;
        _reset = 1'b1;
        step(1'b0, 4'd3, 1'b0, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/eclair_datapath_core.md
Name: eclair_datapath_core

Overview:
Datapath slice for the ECLair microcoded CPU. It contains three parts:
- a 16-bit ALU with arithmetic and logic modes;
- a Z result register loaded from the ALU;
- a loadable program counter preset from Z, plus a 3-to-8 active-low register-load decoder.

It sits between the microcode latch (control inputs) and the register file, memory address path and program counter.

Parameters:
WIDTH, 16, data width of ALU operands, Z register and PC
PC_RESET, 0, value PC takes on reset

Ports:
clk  input  1  system clock; all state updates on rising edge
_reset  input  1  asynchronous active-low reset
alu_mode  input  1  0=arithmetic, 1=logic
alu_op  input  4  ALU operation select
c_in  input  1  carry in (arithmetic mode only)
x  input  WIDTH  operand X
y  input  WIDTH  operand Y
alu_z  output  WIDTH  combinational ALU result
z_load  input  1  capture alu_z into reg_z at clock edge
reg_z  output  WIDTH  Z register
pc_ce  input  1  PC increment enable
pc_load  input  1  PC load from reg_z
pc  output  WIDTH  program counter
dmx_en  input  1  decoder enable, active-high
dmx_sel  input  3  decoder select
dmx_out  output  8  decoded outputs, active-low
flags  output  4  {V,N,Z,C}; see Optional Feature

Behaviour:
- Reset (_reset=0, asynchronous): reg_z=0, pc=PC_RESET, flags=0. Combinational outputs are unaffected by reset.
- Arithmetic mode: result = A+B+c_in at WIDTH+1 bits. alu_z = low WIDTH bits; C = bit WIDTH.
- Arithmetic operand pairs (A,B) by alu_op:
  - 0: (X,0)
  - 1: (X,Y)
  - 2: (X,~Y), which is X-Y when c_in=1
  - 3: (X,all-ones), which is X-1 when c_in=0
  - 4: (Y,0)
  - 5: (~X,Y), which is Y-X when c_in=1
  - 6: (X,X), which is a shift left
  - 7: (0,0)
  - 8-15: reserved; alu_z=0, C=0, V=0
- Logic mode (74181 active-high table, C=0, V=0), by alu_op:
  - 0: ~X
  - 1: ~(X|Y)
  - 2: ~X&Y
  - 3: 0
  - 4: ~(X&Y)
  - 5: ~Y
  - 6: X^Y
  - 7: X&~Y
  - 8: ~X|Y
  - 9: ~(X^Y)
  - 10: Y
  - 11: X&Y
  - 12: all-ones
  - 13: X|~Y
  - 14: X|Y
  - 15: X
- V = signed overflow of A+B+c_in: A and B have equal MSBs and the result MSB differs. N = alu_z MSB. Zf = (alu_z==0).
- reg_z: loads alu_z on the clock edge when z_load=1, otherwise holds. No bypass: alu_z → reg_z has 1-cycle latency.
- PC priority per edge: pc_load over pc_ce over hold.
  - pc_load=1: pc ← reg_z value before the edge, so simultaneous z_load and pc_load gives PC the old Z.
  - pc_ce=1: pc ← pc+1 mod 2^WIDTH; 0xFFFF wraps to 0x0000 with no carry output.
- Decoder, purely combinational:
  - dmx_en=0: dmx_out=8'hFF.
  - dmx_en=1: dmx_out[dmx_sel]=0, all other bits 1.
- X/Z on any control input: outputs may be X. No other checking is required.

Optional Feature:
Macro ALU_FLAGS_EN.
- Defined: flags register {V,N,Zf,C} computed from the current ALU result. It loads on the same edge and with the same z_load as reg_z, and clears on reset.
- Undefined: the flags port remains present and is tied to 4'b0000. No flag logic is synthesized.

Test Plan:
- Reset: assert _reset=0 asynchronously mid-cycle → reg_z=0, pc=PC_RESET=0, flags=0 immediately, without waiting for a clock edge.
- Subtraction: mode=0, op=2, c_in=1, x=0x0005, y=0x0007 → alu_z=0xFFFE, C=0, N=1. After z_load, reg_z=0xFFFE (with ALU_FLAGS_EN, flags=4'b0100).
- Overflow: mode=0, op=1, c_in=0, x=0x7FFF, y=0x0001 → alu_z=0x8000, V=1, N=1, C=0.
- Logic sweep: mode=1, all 16 ops with x=0xF0F0, y=0xCCCC → e.g. op6=0x3C3C, op11=0xC0C0, op14=0xFCFC, op3=0x0000, op12=0xFFFF.
- PC: load reg_z=0xFFFE via pc_load, then pc_ce for 3 cycles → 0xFFFF, 0x0000, 0x0001. With pc_load and pc_ce both high, load wins. With z_load and pc_load on the same edge, pc takes the old reg_z.
- Decoder: dmx_en=1, sel=0..7 → 8'hFE, FD, FB, F7, EF, DF, BF, 7F. dmx_en=0 with any sel → 8'hFF.
